knn_vote_selector: RTL

Downstream stage of `distance_calculator` in the KNN system. It consumes one (distance, data_type) result per training sample and keeps a sorted list of the K smallest distances. After the final sample it runs a majority vote over the K nearest types. It presents the classified type, plus the nearest distance, to the system controller.

---
 rtl/knn_pkg.sv | 26 ++
 rtl/knn_vote_selector_if.sv | 29 ++
 rtl/knn_sorted_insert.sv | 69 ++++++
 rtl/knn_vote_selector.sv | 130 +++++++++++++
 4 files changed

// File: rtl/knn_pkg.sv
// Shared definitions for the KNN vote selector: default widths, FSM states and
// width helpers for the vote counters and scan indices.
package knn_pkg;

    localparam int unsigned KNN_K      = 5;
    localparam int unsigned KNN_W      = 32;
    localparam int unsigned KNN_TYPE_W = 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        VOTE    = 3'd2,
        DECIDE  = 3'd3,
        DONE    = 3'd4
    } state_e;

    // A counter must hold 0..k inclusive
    function automatic int unsigned cnt_width(input int unsigned k);
        return $clog2(k + 1);
    endfunction

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/knn_vote_selector_if.sv
// Sample-in / result-out bundle between the distance stage, the vote selector
// and the system controller.
interface knn_vote_selector_if
    import knn_pkg::*;
#(
    parameter int unsigned W      = KNN_W,
    parameter int unsigned TYPE_W = KNN_TYPE_W
);
    logic              start;
    logic              sample_valid;
    logic              sample_last;
    logic [W-1:0]      distance;
    logic [TYPE_W-1:0] data_type;
    logic              sample_ready;
    logic              busy;
    logic              result_valid;
    logic [TYPE_W-1:0] result_type;
    logic [W-1:0]      nearest_distance;

    modport master (
        output start, sample_valid, sample_last, distance, data_type,
        input  sample_ready, busy, result_valid, result_type, nearest_distance
    );

    modport slave (
        input  start, sample_valid, sample_last, distance, data_type,
        output sample_ready, busy, result_valid, result_type, nearest_distance
    );
endinterface

// File: rtl/knn_sorted_insert.sv
// K-entry list kept sorted by distance; one parallel compare-and-shift insert
// per cycle, ties resolved in arrival order.
module knn_sorted_insert #(
    parameter int unsigned K      = 5,
    parameter int unsigned W      = 32,
    parameter int unsigned TYPE_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_insert,
    input  logic [W-1:0]      i_distance,
    input  logic [TYPE_W-1:0] i_type,
    output logic              o_valid [K],
    output logic [W-1:0]      o_dist  [K],
    output logic [TYPE_W-1:0] o_type  [K]
);
    logic              r_valid [K];
    logic [W-1:0]      r_dist  [K];
    logic [TYPE_W-1:0] r_type  [K];

    // Slot is empty or strictly farther than the new sample; monotone across ranks
    logic w_after [K];

    always_comb begin
        for (int i = 0; i < K; i++) begin
            w_after[i] = !r_valid[i] || (r_dist[i] > i_distance);
        end
    end

    // First w_after slot takes the new sample, later slots take their predecessor
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < K; i++) begin
                r_valid[i] <= 1'b0;
                r_dist[i]  <= '0;
                r_type[i]  <= '0;
            end
        end else if (i_clear) begin
            for (int i = 0; i < K; i++) begin
                r_valid[i] <= 1'b0;
            end
        end else if (i_insert) begin
            if (w_after[0]) begin
                r_valid[0] <= 1'b1;
                r_dist[0]  <= i_distance;
                r_type[0]  <= i_type;
            end
            for (int i = 1; i < K; i++) begin
                if (w_after[i]) begin
                    if (w_after[i-1]) begin
                        r_valid[i] <= r_valid[i-1];
                        r_dist[i]  <= r_dist[i-1];
                        r_type[i]  <= r_type[i-1];
                    end else begin
                        r_valid[i] <= 1'b1;
                        r_dist[i]  <= i_distance;
                        r_type[i]  <= i_type;
                    end
                end
            end
        end
    end

    assign o_valid = r_valid;
    assign o_dist  = r_dist;
    assign o_type  = r_type;

endmodule

// File: rtl/knn_vote_selector.sv
// KNN back end: collects the K nearest samples, counts one vote per cycle,
// scans the class counters and presents the winning class.
module knn_vote_selector
    import knn_pkg::*;
#(
    parameter int unsigned K      = KNN_K,
    parameter int unsigned W      = KNN_W,
    parameter int unsigned TYPE_W = KNN_TYPE_W
) (
    input logic          clk,
    input logic          rst,
    knn_vote_selector_if.slave bus
);
    localparam int unsigned NTYPES = 1 << TYPE_W;
    localparam int unsigned CNT_W  = cnt_width(K);
    localparam int unsigned VIDX_W = idx_width(K);

    state_e r_state, w_state_nxt;
    logic   w_accept, w_clear;

    logic              w_list_valid [K];
    logic [W-1:0]      w_list_dist  [K];
    logic [TYPE_W-1:0] w_list_type  [K];

    logic [CNT_W-1:0]  r_cnt [NTYPES];
    logic [VIDX_W-1:0] r_vidx;
    logic [TYPE_W-1:0] r_didx;
    logic [CNT_W-1:0]  r_best_cnt;
    logic [TYPE_W-1:0] r_best_type;
    logic [TYPE_W-1:0] w_final_type;
    logic              w_vote_last, w_decide_last;

    logic              r_sample_ready, r_busy, r_result_valid;
    logic [TYPE_W-1:0] r_result_type;
    logic [W-1:0]      r_nearest;

    knn_sorted_insert #(.K(K), .W(W), .TYPE_W(TYPE_W)) u_list (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_clear),
        .i_insert   (w_accept),
        .i_distance (bus.distance),
        .i_type     (bus.data_type),
        .o_valid    (w_list_valid),
        .o_dist     (w_list_dist),
        .o_type     (w_list_type)
    );

    assign w_vote_last   = (r_vidx == VIDX_W'(K - 1));
    assign w_decide_last = (r_didx == TYPE_W'(NTYPES - 1));
    // Strict compare keeps the lowest class index on ties
    assign w_final_type  = (r_cnt[r_didx] > r_best_cnt) ? r_didx : r_best_type;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // start overrides everything, including a coincident sample
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_clear     = 1'b0;
        if (bus.start) begin
            w_state_nxt = COLLECT;
            w_clear     = 1'b1;
        end else begin
            case (r_state)
                COLLECT: begin
                    if (bus.sample_valid) begin
                        w_accept = 1'b1;
                        if (bus.sample_last) w_state_nxt = VOTE;
                    end
                end
                VOTE:    if (w_vote_last)   w_state_nxt = DECIDE;
                DECIDE:  if (w_decide_last) w_state_nxt = DONE;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NTYPES; i++) r_cnt[i] <= '0;
            r_vidx         <= '0;
            r_didx         <= '0;
            r_best_cnt     <= '0;
            r_best_type    <= '0;
            r_sample_ready <= 1'b0;
            r_busy         <= 1'b0;
            r_result_valid <= 1'b0;
            r_result_type  <= '0;
            r_nearest      <= '0;
        end else begin
            r_sample_ready <= (w_state_nxt == COLLECT);
            r_busy         <= (w_state_nxt == COLLECT) || (w_state_nxt == VOTE) ||
                              (w_state_nxt == DECIDE);
            r_result_valid <= (w_state_nxt == DONE);
            if (w_clear) begin
                for (int i = 0; i < NTYPES; i++) r_cnt[i] <= '0;
                r_vidx      <= '0;
                r_didx      <= '0;
                r_best_cnt  <= '0;
                r_best_type <= '0;
            end else if (r_state == VOTE) begin
                if (w_list_valid[r_vidx]) begin
                    r_cnt[w_list_type[r_vidx]] <= r_cnt[w_list_type[r_vidx]] + CNT_W'(1);
                end
                r_vidx <= w_vote_last ? '0 : r_vidx + VIDX_W'(1);
            end else if (r_state == DECIDE) begin
                if (r_cnt[r_didx] > r_best_cnt) begin
                    r_best_cnt  <= r_cnt[r_didx];
                    r_best_type <= r_didx;
                end
                r_didx <= r_didx + TYPE_W'(1);
                if (w_decide_last) begin
                    r_result_type <= w_final_type;
                    r_nearest     <= w_list_dist[0];
                end
            end
        end
    end

    assign bus.sample_ready     = r_sample_ready;
    assign bus.busy             = r_busy;
    assign bus.result_valid     = r_result_valid;
    assign bus.result_type      = r_result_type;
    assign bus.nearest_distance = r_nearest;

endmodule
